mult_seq_display: RTL

MULT_SEQ_DISPLAY -- requirements
Module: mult_seq_display

---
 rtl/mult_seq_display.sv | 112 +++++++++++
 1 files changed

// File: rtl/mult_seq_display.sv
// mult_seq_display: shift-add sequential multiplier with a multiplexed hex display of the last product.
module mult_seq_display #(
  parameter int WIDTH       = 4,
  parameter int REFRESH_DIV = 25000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [WIDTH-1:0]              a,
  input  logic [WIDTH-1:0]              b,
  input  logic                          blank_lz,
  output logic                          busy,
  output logic                          done,
  output logic [2*WIDTH-1:0]            product,
  output logic [6:0]                    segments,
  output logic [(2*WIDTH+3)/4-1:0]      anodes
);
  localparam int NDIG = (2*WIDTH+3)/4;
  localparam int PW   = 2*WIDTH;
  localparam int DW   = 4*NDIG;
  localparam int CW   = $clog2(WIDTH+1);
  localparam int RW   = $clog2(REFRESH_DIV);
  localparam int IW   = NDIG > 1 ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic [PW-1:0]    acc, mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    cnt;
  logic [RW-1:0]    rcnt;
  logic [IW-1:0]    idx;
  logic [DW-1:0]    pp, upper;
  logic [6:0]       glyph;
  logic             blank;

  always_ff @(posedge clk)
    if (!rst) state <= IDLE;
    else      state <= state_nxt;

  always_comb
    state_nxt = (state == IDLE) ? (start ? RUN : IDLE) :
                (state == RUN)  ? (cnt == CW'(1) ? DONE : RUN) : IDLE;

  assign busy = state != IDLE;

  always_ff @(posedge clk)
    if (!rst) begin
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      product <= '0;
      done    <= 1'b0;
    end else begin
      done <= state == DONE;
      if (state == IDLE && start) begin
        mcand  <= PW'(a);
        mplier <= b;
        acc    <= '0;
        cnt    <= CW'(WIDTH);
      end else if (state == RUN) begin
        acc    <= mplier[0] ? acc + mcand : acc;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - CW'(1);
      end
      if (state == DONE) product <= acc;
    end

  always_ff @(posedge clk)
    if (!rst) begin
      rcnt <= '0;
      idx  <= '0;
    end else if (rcnt == RW'(REFRESH_DIV-1)) begin
      rcnt <= '0;
      idx  <= (idx == IW'(NDIG-1)) ? '0 : idx + IW'(1);
    end else begin
      rcnt <= rcnt + RW'(1);
    end

  // upper holds the current digit and everything above it, so it doubles as the leading-zero test
  assign pp    = DW'(product);
  assign upper = pp >> {idx, 2'b00};
  assign blank = blank_lz && idx != '0 && upper == '0;

  always_comb begin
    glyph = 7'b1111111;
    case (upper[3:0])
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      4'hF: glyph = 7'b0001110;
      default: glyph = 7'b1111111;
    endcase
  end

  assign segments = blank ? 7'b1111111 : glyph;
  assign anodes   = ~(NDIG'(1) << idx);
endmodule
